// File: rtl/pc_gen_pkg.sv
// Shared core constants and encodings for the IF-stage program-counter generator.
package pc_gen_pkg;

  // Architectural reset vector and default sequential fetch step in bytes.
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam int unsigned PC_STEP      = 4;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SRC_EX   = 3'd0,
    SRC_BR   = 3'd1,
    SRC_RAS  = 3'd2,
    SRC_SEQ  = 3'd3,
    SRC_HOLD = 3'd4
  } pc_src_e;

  // Fetch FSM: BOOT is the single non-requesting cycle after reset.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Return-address stack as a circular buffer. top_ptr indexes the most recent
// entry; a push onto a full stack silently overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             pc_clk,
  input  logic             pc_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [CW-1:0]    count;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  always_comb begin
    ptr_inc = top_ptr + PW'(1);
    ptr_dec = top_ptr - PW'(1);
  end

  // Pointer and occupancy; clear only drops the count, the pointer is arbitrary.
  always_ff @(posedge pc_clk or posedge pc_rst) begin
    if (pc_rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && pop) begin
      // Replace the top in place: occupancy and pointer unchanged.
      count <= count;
    end else if (push) begin
      top_ptr <= ptr_inc;
      if (count != COUNT_FULL) begin
        count <= count + CW'(1);
      end
    end else if (pop && (count != '0)) begin
      top_ptr <= ptr_dec;
      count   <= count - CW'(1);
    end
  end

  // Entry storage is deliberately not reset; count guards its validity.
  always_ff @(posedge pc_clk) begin
    if (!clear && push) begin
      if (pop) begin
        mem[top_ptr] <= push_addr;
      end else begin
        mem[ptr_inc] <= push_addr;
      end
    end
  end

  // Top-of-stack view and empty flag.
  always_comb begin
    top   = mem[top_ptr];
    empty = (count == '0);
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: holds the PC, offers it to fetch, and picks the next PC
// from exception redirect, branch redirect, predicted return, or sequential step.
//
// Handshake: pc_valid/pc_ready follow strict valid/ready rules. A fetch is
// consumed on a cycle where pc_valid & pc_ready; while pc_valid=1 and
// pc_ready=0 the PC is held unless a redirect or a RAS pop replaces it.
// pc_valid never depends combinationally on pc_ready.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter int unsigned        STEP      = PC_STEP,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic             pc_clk,
  input  logic             pc_rst,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  input  logic             pc_ready,
  input  logic             stall,
  input  logic             ex_redirect,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             br_redirect,
  input  logic [WIDTH-1:0] br_target,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] ras_push_addr,
  input  logic             ras_pop,
  output logic             ras_empty,
  output pc_state_e        dbg_state
);

  pc_state_e        state;
  pc_state_e        state_next;
  pc_src_e          src;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             pop_take;
  logic             push_take;
  logic             is_run;

  // FSM state register.
  always_ff @(posedge pc_clk or posedge pc_rst) begin
    if (pc_rst) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: BOOT lasts exactly one cycle; RUN is left only via reset.
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  // FSM outputs: fetch requests are offered only in RUN.
  always_comb begin
    is_run    = (state == ST_RUN);
    pc_valid  = is_run;
    dbg_state = state;
  end

  // Priority selection of the next PC source and the RAS side effects.
  always_comb begin
    pop_take  = is_run && ras_pop && !stall && !ras_empty
                && !ex_redirect && !br_redirect;
    push_take = ras_push && !ex_redirect;
    if (ex_redirect) begin
      src = SRC_EX;
    end else if (br_redirect) begin
      src = SRC_BR;
    end else if (pop_take) begin
      src = SRC_RAS;
    end else if (is_run && pc_ready && !stall) begin
      src = SRC_SEQ;
    end else begin
      src = SRC_HOLD;
    end
  end

  // Next-PC mux; the sequential step wraps modulo 2^WIDTH.
  always_comb begin
    case (src)
      SRC_EX:   pc_next = ex_target;
      SRC_BR:   pc_next = br_target;
      SRC_RAS:  pc_next = ras_top;
      SRC_SEQ:  pc_next = pc + WIDTH'(STEP);
      default:  pc_next = pc;
    endcase
  end

  // PC register.
  always_ff @(posedge pc_clk or posedge pc_rst) begin
    if (pc_rst) begin
      pc <= RESET_VEC;
    end else begin
      pc <= pc_next;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .pc_clk    (pc_clk),
    .pc_rst    (pc_rst),
    .push      (push_take),
    .push_addr (ras_push_addr),
    .pop       (pop_take),
    .clear     (ex_redirect),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a queue-based reference model checked every cycle.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam logic [W-1:0] STEP_W = W'(PC_STEP);

  logic         pc_clk;
  logic         pc_rst;
  logic [W-1:0] pc;
  logic         pc_valid;
  logic         pc_ready;
  logic         stall;
  logic         ex_redirect;
  logic [W-1:0] ex_target;
  logic         br_redirect;
  logic [W-1:0] br_target;
  logic         ras_push;
  logic [W-1:0] ras_push_addr;
  logic         ras_pop;
  logic         ras_empty;
  pc_state_e    dbg_state;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .WIDTH     (W),
    .RESET_VEC (W'(PC_RESET_VEC)),
    .STEP      (PC_STEP),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .pc_clk        (pc_clk),
    .pc_rst        (pc_rst),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .stall         (stall),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .br_redirect   (br_redirect),
    .br_target     (br_target),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .ras_pop       (ras_pop),
    .ras_empty     (ras_empty),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial pc_clk = 1'b0;
  always #5 pc_clk = ~pc_clk;

  // ---------------- reference model ----------------
  // Behavioural view: a PC, a "first cycle after reset" flag, and the return
  // stack as a plain queue whose back element is the predicted return.
  logic [W-1:0] m_pc;
  logic         m_boot;
  logic [W-1:0] exp_q[$];

  always @(posedge pc_clk or posedge pc_rst) begin
    logic [W-1:0] npc;
    logic         can_pop;
    if (pc_rst) begin
      m_pc   = W'(PC_RESET_VEC);
      m_boot = 1'b1;
      exp_q.delete();
    end else begin
      can_pop = !m_boot && ras_pop && !stall && (exp_q.size() > 0)
                && !ex_redirect && !br_redirect;
      if (ex_redirect)                          npc = ex_target;
      else if (br_redirect)                     npc = br_target;
      else if (can_pop)                         npc = exp_q[exp_q.size()-1];
      else if (!m_boot && pc_ready && !stall)   npc = m_pc + STEP_W;
      else                                      npc = m_pc;
      if (ex_redirect) begin
        exp_q.delete();
      end else if (ras_push && can_pop) begin
        exp_q[exp_q.size()-1] = ras_push_addr;
      end else if (ras_push) begin
        exp_q.push_back(ras_push_addr);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      end else if (can_pop) begin
        void'(exp_q.pop_back());
      end
      m_pc   = npc;
      m_boot = 1'b0;
    end
  end

  // ---------------- scoreboard: every cycle on the falling edge ----------------
  always @(negedge pc_clk) begin
    if (!pc_rst) begin
      checks++;
      if (pc !== m_pc) begin
        errors++;
        $display("FAIL model_pc: got %h expected %h at %0t", pc, m_pc, $time);
      end
      checks++;
      if (pc_valid !== !m_boot) begin
        errors++;
        $display("FAIL model_valid: got %b expected %b at %0t", pc_valid, !m_boot, $time);
      end
      checks++;
      if (ras_empty !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL model_empty: got %b expected %b at %0t", ras_empty,
                 (exp_q.size() == 0), $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    stall = 0; ex_redirect = 0; ex_target = '0; br_redirect = 0; br_target = '0;
    ras_push = 0; ras_push_addr = '0; ras_pop = 0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge pc_clk);
    #1;
  endtask

  task automatic expect_pc(input string name, input logic [W-1:0] exp);
    checks++;
    if (pc !== exp) begin
      errors++;
      $display("FAIL %s: pc got %h expected %h", name, pc, exp);
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_inputs();
    pc_ready = 0;
    pc_rst   = 1;
    #12;
    expect_pc("reset_pc", 32'h0);
    expect_bit("reset_valid", pc_valid, 1'b0);
    expect_bit("reset_empty", ras_empty, 1'b1);
    expect_bit("reset_state_boot", dbg_state == ST_BOOT, 1'b1);
    @(posedge pc_clk); #1;
    pc_rst   = 0;
    pc_ready = 1;
    expect_bit("boot_valid", pc_valid, 1'b0);
    step(); expect_pc("seq0", 32'h0); expect_bit("run_valid", pc_valid, 1'b1);
    step(); expect_pc("seq4", 32'h4);
    step(); expect_pc("seq8", 32'h8);
    step(); expect_pc("seq12", 32'hC);
    step(); expect_pc("seq16", 32'h10);

    // Stall three cycles with a branch redirect in the second.
    stall = 1;
    step(); expect_pc("stall_hold", 32'h10);
    br_redirect = 1; br_target = 32'h80;
    step(); expect_pc("stall_br", 32'h80);
    br_redirect = 0;
    step(); expect_pc("stall_hold_br", 32'h80);
    stall = 0;
    step(); expect_pc("stall_release", 32'h84);

    // pc_ready low holds the request.
    pc_ready = 0;
    step(); expect_pc("not_ready_hold", 32'h84);
    pc_ready = 1;

    // Exception beats branch and clears the RAS; a concurrent push is dropped.
    ras_push = 1; ras_push_addr = 32'h500;
    step(); expect_bit("pre_ex_nonempty", ras_empty, 1'b0);
    ras_push_addr = 32'h504;
    ex_redirect = 1; ex_target = 32'h1c00_0000;
    br_redirect = 1; br_target = 32'h40;
    step(); expect_pc("ex_over_br", 32'h1c00_0000);
    expect_bit("ex_clears_ras", ras_empty, 1'b1);
    idle_inputs();

    // Overfill a depth-4 RAS, then pop five times.
    for (int i = 0; i < 5; i++) begin
      ras_push = 1; ras_push_addr = 32'h100 + 32'(4 * i);
      step();
    end
    ras_push = 0;
    ras_pop  = 1;
    step(); expect_pc("pop1", 32'h110);
    step(); expect_pc("pop2", 32'h10C);
    step(); expect_pc("pop3", 32'h108);
    step(); expect_pc("pop4", 32'h104);
    step(); expect_pc("pop5_ignored", 32'h108);
    expect_bit("pop5_empty", ras_empty, 1'b1);
    ras_pop = 0;

    // Push and pop in the same cycle replace the top.
    ras_push = 1; ras_push_addr = 32'h300;
    step();
    ras_pop = 1; ras_push_addr = 32'h200;
    step(); expect_pc("pushpop_old_top", 32'h300);
    expect_bit("pushpop_count", ras_empty, 1'b0);
    ras_push = 0;
    step(); expect_pc("pushpop_new_top", 32'h200);
    expect_bit("pushpop_then_empty", ras_empty, 1'b1);
    ras_pop = 0;

    // Pop suppressed by stall.
    ras_push = 1; ras_push_addr = 32'h700;
    step();
    ras_push = 0; ras_pop = 1; stall = 1;
    step(); expect_pc("pop_stalled", 32'h204);
    stall = 0;
    step(); expect_pc("pop_after_stall", 32'h700);
    ras_pop = 0;

    // Wrap-around at the top of the address space.
    br_redirect = 1; br_target = 32'hFFFF_FFFC;
    step(); expect_pc("wrap_pre", 32'hFFFF_FFFC);
    br_redirect = 0;
    step(); expect_pc("wrap", 32'h0);

    // Random ready/stall/push/pop traffic checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      pc_ready      = 1'($urandom_range(0, 1));
      stall         = ($urandom_range(0, 3) == 0);
      ras_push      = ($urandom_range(0, 3) == 0);
      ras_push_addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      ras_pop       = ($urandom_range(0, 2) == 0);
      br_redirect   = ($urandom_range(0, 9) == 0);
      br_target     = 32'h2000 + 32'($urandom_range(0, 63) * 4);
      ex_redirect   = ($urandom_range(0, 19) == 0);
      ex_target     = 32'h1c00_0000;
      step();
    end
    idle_inputs();
    pc_ready = 1;
    step();

    // Asynchronous reset mid-run, released away from the edge.
    #2;
    pc_rst = 1;
    #1;
    expect_pc("async_rst_pc", 32'h0);
    expect_bit("async_rst_valid", pc_valid, 1'b0);
    expect_bit("async_rst_empty", ras_empty, 1'b1);
    @(negedge pc_clk);
    pc_rst = 0;
    step(); expect_pc("post_rst_first", 32'h0);
    expect_bit("post_rst_valid", pc_valid, 1'b1);
    step(); expect_pc("post_rst_seq", 32'h4);

    // Redirect during BOOT is honoured and BOOT still ends.
    pc_rst = 1; #1; pc_rst = 0;
    br_redirect = 1; br_target = 32'h900;
    step(); expect_pc("boot_redirect", 32'h900);
    expect_bit("boot_redirect_valid", pc_valid, 1'b1);
    br_redirect = 0;
    step(); expect_pc("boot_redirect_seq", 32'h904);

    repeat (2) @(negedge pc_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
